// File: rtl/bus_burst_reader.sv
// Bus read initiator that fetches a byte burst over the rd_req/rd_ack handshake
// into a first-word-fall-through FIFO drained by a consumer.
module bus_burst_reader #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 12
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      start_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dma_req,
  output logic [15:0]      addr_out,
  output logic             rd_req,
  input  logic             rd_ack,
  input  logic [7:0]       data_in,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]       state, state_next;
  logic             rd_req_next;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             take, accept, push, pop, flush;

  assign take   = rd_req & rd_ack;
  assign accept = (state == S_IDLE) && start && !abort;
  assign push   = (state == S_FETCH) && !abort && take;
  assign flush  = (abort && ((state == S_IDLE) || (state == S_FETCH))) || (state == S_FLUSH);
  assign pop    = out_valid && out_ready && !flush;

  assign remaining_next = remaining - {{(LEN_W-1){1'b0}}, take};

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else
      count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // A raised request is only ever released by its ack; new requests need FIFO space.
  always_comb begin
    state_next  = state;
    rd_req_next = rd_req;
    case (state)
      S_IDLE: begin
        rd_req_next = 1'b0;
        if (accept)
          state_next = (length == '0) ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          state_next  = S_FLUSH;
          rd_req_next = rd_req & ~rd_ack;
        end else if (take && (remaining_next == '0)) begin
          state_next  = S_FINISH;
          rd_req_next = 1'b0;
        end else if (rd_req && !rd_ack) begin
          rd_req_next = 1'b1;
        end else begin
          rd_req_next = (remaining_next != '0) && (count_next < CNT_DEPTH);
        end
      end
      S_FINISH: begin
        state_next  = S_IDLE;
        rd_req_next = 1'b0;
      end
      S_FLUSH: begin
        rd_req_next = rd_req & ~rd_ack;
        if (!rd_req || rd_ack)
          state_next = S_IDLE;
      end
      default: begin
        state_next  = S_IDLE;
        rd_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rd_req    <= 1'b0;
      addr_out  <= 16'h0000;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state  <= state_next;
      rd_req <= rd_req_next;
      count  <= count_next;
      if (accept) begin
        addr_out  <= start_addr;
        remaining <= length;
      end else if (push) begin
        addr_out  <= addr_out + 16'h0001;
        remaining <= remaining_next;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push)
      mem[wr_ptr] <= data_in;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign busy      = (state != S_IDLE);
  assign dma_req   = busy;
  assign done      = (state == S_FINISH);

endmodule
